// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: load/data inputs and scanned display outputs of the 7-segment driver
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic                  hex_mode;
  logic                  lz_blank;
  logic [DIGITS-1:0]     blink_mask;
  logic [6:0]            leds;
  logic [DIGITS-1:0]     dig_en;
  logic                  frame_start;
  logic                  pending;
  modport master (
    output load, value, hex_mode, lz_blank, blink_mask,
    input  leds, dig_en, frame_start, pending
  );
  modport slave (
    input  load, value, hex_mode, lz_blank, blink_mask,
    output leds, dig_en, frame_start, pending
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed multi-digit 7-segment driver with frame-aligned updates
module seg7_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 64
) (
  input logic               clk,
  input logic               reset_n,
  seg7_scan_driver_if.slave bus
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam int W  = 5*DIGITS + 2;
  localparam int HX = 4*DIGITS;
  localparam int LZ = 4*DIGITS + 1;
  localparam int BM = 4*DIGITS + 2;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [DW-1:0]     div_q, div_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BW-1:0]     fcnt_q, fcnt_d;
  logic              phase_q, phase_d;
  logic [W-1:0]      pend_q, pend_d, act_q, act_d, in_w;
  logic              pending_q, pending_d, valid_q, valid_d;
  logic [6:0]        leds_q, leds_d;
  logic [DIGITS-1:0] dig_en_q, dig_en_d;
  logic              fs_q, fs_d;
  logic              tick, bnd, lz, blank;
  logic [3:0]        nib;
  // Outputs are computed from next-state so leds and dig_en always switch on the same edge.
  always_comb begin
    in_w      = {bus.blink_mask, bus.lz_blank, bus.hex_mode, bus.value};
    tick      = div_q == DW'(SCAN_DIV - 1);
    bnd       = tick && idx_q == IW'(DIGITS - 1);
    div_d     = tick ? '0 : div_q + 1'b1;
    idx_d     = bnd ? '0 : tick ? idx_q + 1'b1 : idx_q;
    fcnt_d    = !bnd ? fcnt_q : fcnt_q == BW'(BLINK_DIV - 1) ? '0 : fcnt_q + 1'b1;
    phase_d   = phase_q ^ (bnd && fcnt_q == BW'(BLINK_DIV - 1));
    pend_d    = (bus.load && !bnd) ? in_w : pend_q;
    pending_d = !bnd && (pending_q || bus.load);
    act_d     = (bnd && bus.load) ? in_w : (bnd && pending_q) ? pend_q : act_q;
    valid_d   = valid_q || (bnd && (bus.load || pending_q));
    nib       = act_d[4*idx_d +: 4];
    lz        = act_d[LZ] && idx_d != '0 && (act_d[HX-1:0] >> (4*idx_d)) == '0;
    blank     = !valid_d || (phase_d && act_d[BM + idx_d]) || lz || (!act_d[HX] && nib > 4'd9);
    leds_d    = blank ? 7'h7f : GLYPH[nib];
    dig_en_d  = DIGITS'(1) << idx_d;
    fs_d      = bnd;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      div_q     <= '0;
      idx_q     <= '0;
      fcnt_q    <= '0;
      phase_q   <= 1'b0;
      pend_q    <= '0;
      act_q     <= '0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      leds_q    <= 7'h7f;
      dig_en_q  <= DIGITS'(1);
      fs_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      fcnt_q    <= fcnt_d;
      phase_q   <= phase_d;
      pend_q    <= pend_d;
      act_q     <= act_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      leds_q    <= leds_d;
      dig_en_q  <= dig_en_d;
      fs_q      <= fs_d;
    end
  assign bus.leds        = leds_q;
  assign bus.dig_en      = dig_en_q;
  assign bus.frame_start = fs_q;
  assign bus.pending     = pending_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench; expected frames are queued at load time and
// popped on each frame_start, then compared against every scanned cycle of the frame.
module tb_seg7_scan_driver;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010, G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0010000, GA = 7'b0001000;
  logic clk, reset_n;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [27:0] cur;
  logic [27:0] q[$];
  seg7_scan_driver_if #(.DIGITS(4)) ifc();
  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(ifc)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!reset_n) begin
      cyc = 0;
      cur = {4{BL}};
      q.delete();
    end else begin
      if (ifc.frame_start && q.size() > 0) cur = q.pop_front();
      chk("dig_en", ifc.dig_en, 4'(1) << ((cyc / 4) % 4));
      chk("frame_start", ifc.frame_start, (cyc % 16 == 0) && cyc != 0);
      chk("leds", ifc.leds, cur[((cyc / 4) % 4) * 7 +: 7]);
      cyc++;
    end
  end
  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifc.frame_start && n < 40);
    chk("fs_seen", ifc.frame_start, 1);
  endtask
  task automatic drive(input logic [15:0] v, input logic h, input logic l, input logic [3:0] m);
    ifc.load = 1; ifc.value = v; ifc.hex_mode = h; ifc.lz_blank = l; ifc.blink_mask = m;
  endtask
  task automatic do_load(input logic [15:0] v, input logic h, input logic l, input logic [3:0] m,
                         input logic [27:0] e);
    repeat (5) @(negedge clk);
    q.push_back(e);
    drive(v, h, l, m);
    @(negedge clk);
    ifc.load = 0;
    chk("pending_set", ifc.pending, 1);
    wait_fs();
    chk("pending_clr", ifc.pending, 0);
  endtask
  task automatic chk_reset();
    chk("rst_leds", ifc.leds, BL);
    chk("rst_dig_en", ifc.dig_en, 4'b0001);
    chk("rst_fs", ifc.frame_start, 0);
    chk("rst_pending", ifc.pending, 0);
  endtask
  initial begin
    reset_n = 0;
    ifc.load = 0; ifc.value = '0; ifc.hex_mode = 0; ifc.lz_blank = 0; ifc.blink_mask = '0;
    repeat (3) @(posedge clk);
    #1 chk_reset();
    reset_n = 1;
    repeat (40) @(negedge clk);
    wait_fs();
    do_load(16'h1234, 0, 0, 4'b0000, {G1, G2, G3, G4});
    do_load(16'h00A5, 0, 1, 4'b0000, {BL, BL, BL, G5});
    do_load(16'h00A5, 1, 1, 4'b0000, {BL, BL, GA, G5});
    do_load(16'h0000, 0, 1, 4'b0000, {BL, BL, BL, G0});
    repeat (5) @(negedge clk);
    drive(16'h1111, 0, 0, 4'b0000);
    @(negedge clk);
    drive(16'h2222, 0, 0, 4'b0000);
    q.push_back({4{G2}});
    @(negedge clk);
    ifc.load = 0;
    chk("pending_last", ifc.pending, 1);
    wait_fs();
    chk("pending_last_clr", ifc.pending, 0);
    repeat (15) @(negedge clk);
    q.push_back({G9, G8, G7, G6});
    drive(16'h9876, 0, 0, 4'b0000);
    @(negedge clk);
    ifc.load = 0;
    chk("bypass_fs", ifc.frame_start, 1);
    chk("bypass_pending", ifc.pending, 0);
    chk("bypass_leds", ifc.leds, G6);
    chk("bypass_dig_en", ifc.dig_en, 4'b0001);
    @(negedge clk);
    chk("bypass_pending2", ifc.pending, 0);
    wait_fs();
    repeat (9) @(negedge clk);
    chk("mid_dig2", ifc.dig_en, 4'b0100);
    #1 reset_n = 0;
    #1 chk_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    repeat (5) @(negedge clk);
    q.push_back({4{G8}});
    q.push_back({G8, G8, G8, BL});
    q.push_back({G8, G8, G8, BL});
    q.push_back({4{G8}});
    q.push_back({4{G8}});
    q.push_back({G8, G8, G8, BL});
    drive(16'h8888, 0, 0, 4'b0001);
    @(negedge clk);
    ifc.load = 0;
    chk("blink_pending", ifc.pending, 1);
    repeat (6) wait_fs();
    repeat (16) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
